// File: rtl/data_sync_capture_buf.sv
// Destination-domain capture FIFO behind the data-sync pulse generator, with a valid/ready head and a sticky overflow flag.
// Optional parity checking is enabled by defining DATA_SYNC_CAPTURE_PARITY_EN.
module data_sync_capture_buf #(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   pulse_signal,
    input  logic [BUS_WIDTH-1:0]   unsync_bus,
`ifdef DATA_SYNC_CAPTURE_PARITY_EN
    input  logic                   unsync_parity,
    output logic                   parity_err,
`endif
    input  logic                   sync_ready,
    input  logic                   overflow_clr,
    output logic [BUS_WIDTH-1:0]   sync_bus,
    output logic                   sync_valid,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
`ifdef DATA_SYNC_CAPTURE_PARITY_EN
    localparam int unsigned ENTRY_W = BUS_WIDTH + 1;
`else
    localparam int unsigned ENTRY_W = BUS_WIDTH;
`endif

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] head_entry_nxt;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   head_nxt;
    logic [PTR_W-1:0]   tail;
    logic [OCC_W-1:0]   occ_nxt;
    logic               full;
    logic               pop;
    logic               push_ok;
    logic               drop;

`ifdef DATA_SYNC_CAPTURE_PARITY_EN
    assign entry_in = {unsync_parity, unsync_bus};
`else
    assign entry_in = unsync_bus;
`endif

    assign full     = (occupancy == OCC_W'(DEPTH));
    assign pop      = sync_valid && sync_ready;
    assign push_ok  = pulse_signal && (!full || pop);
    assign drop     = pulse_signal && full && !pop;
    assign head_nxt = pop ? head + PTR_W'(1) : head;
    assign sync_bus = head_entry[BUS_WIDTH-1:0];

    // Next head word: bypass the incoming word when it becomes the sole entry.
    always_comb begin
        head_entry_nxt = mem[head_nxt];
        occ_nxt        = occupancy;
        if (push_ok && (head_nxt == tail)) begin
            head_entry_nxt = entry_in;
        end
        if (push_ok && !pop) begin
            occ_nxt = occupancy + OCC_W'(1);
        end else if (!push_ok && pop) begin
            occ_nxt = occupancy - OCC_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[tail] <= entry_in;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head       <= '0;
            tail       <= '0;
            occupancy  <= '0;
            sync_valid <= 1'b0;
            overflow   <= 1'b0;
            head_entry <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + PTR_W'(1);
            end
            head       <= head_nxt;
            occupancy  <= occ_nxt;
            sync_valid <= (occ_nxt != '0);
            if (occ_nxt != '0) begin
                head_entry <= head_entry_nxt;
            end
            // A new drop takes priority over a clear in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef DATA_SYNC_CAPTURE_PARITY_EN
    // Even parity over data plus check bit; a popped word with odd parity is an error.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            parity_err <= 1'b0;
        end else if (pop && (^head_entry)) begin
            parity_err <= 1'b1;
        end else if (overflow_clr) begin
            parity_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_data_sync_capture_buf.sv
// Scoreboard bench for data_sync_capture_buf: a queue model predicts the head, occupancy and sticky flags.
module tb_data_sync_capture_buf;

    localparam int unsigned BUS_WIDTH = 8;
    localparam int unsigned DEPTH     = 2;

    logic                   CLK;
    logic                   RST;
    logic                   pulse_signal;
    logic [BUS_WIDTH-1:0]   unsync_bus;
    logic                   sync_ready;
    logic                   overflow_clr;
    logic [BUS_WIDTH-1:0]   sync_bus;
    logic                   sync_valid;
    logic                   overflow;
    logic [$clog2(DEPTH):0] occupancy;
`ifdef DATA_SYNC_CAPTURE_PARITY_EN
    logic                   unsync_parity;
    logic                   parity_err;
`endif

    data_sync_capture_buf #(.BUS_WIDTH(BUS_WIDTH), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .pulse_signal (pulse_signal),
        .unsync_bus   (unsync_bus),
`ifdef DATA_SYNC_CAPTURE_PARITY_EN
        .unsync_parity(unsync_parity),
        .parity_err   (parity_err),
`endif
        .sync_ready   (sync_ready),
        .overflow_clr (overflow_clr),
        .sync_bus     (sync_bus),
        .sync_valid   (sync_valid),
        .overflow     (overflow),
        .occupancy    (occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] q[$];
    logic m_ovf  = 1'b0;
    logic m_perr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One clock cycle: drive at negedge, score the pop, then check state after the edge.
    task automatic cycle(input logic pulse, input logic [7:0] data, input logic ready,
                         input logic clr, input logic flip = 1'b0);
        logic pop_m, full_m, drop_m, perr_set;
        logic [8:0] ent;
        @(negedge CLK);
        pulse_signal = pulse;
        unsync_bus   = data;
        sync_ready   = ready;
        overflow_clr = clr;
`ifdef DATA_SYNC_CAPTURE_PARITY_EN
        unsync_parity = (^data) ^ flip;
`endif
        check("valid_pre", 32'(sync_valid), 32'(q.size() != 0));
        pop_m    = (q.size() != 0) && ready;
        full_m   = (q.size() == DEPTH);
        drop_m   = 1'b0;
        perr_set = 1'b0;
        if (pop_m) begin
            ent = q.pop_front();
            check("pop_data", 32'(sync_bus), 32'(ent[7:0]));
            perr_set = ^ent;
        end
        if (pulse) begin
            if (!full_m || pop_m) q.push_back({(^data) ^ flip, data});
            else drop_m = 1'b1;
        end
        m_ovf  = drop_m ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_perr = perr_set ? 1'b1 : (clr ? 1'b0 : m_perr);
        @(posedge CLK);
        #1;
        check("occupancy", 32'(occupancy), 32'(q.size()));
        check("valid", 32'(sync_valid), 32'(q.size() != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) check("head", 32'(sync_bus), 32'(q[0][7:0]));
`ifdef DATA_SYNC_CAPTURE_PARITY_EN
        check("parity_err", 32'(parity_err), 32'(m_perr));
`endif
        pulse_signal = 1'b0;
        sync_ready   = 1'b0;
        overflow_clr = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        pulse_signal = 1'b0;
        unsync_bus = '0;
        sync_ready = 1'b0;
        overflow_clr = 1'b0;
`ifdef DATA_SYNC_CAPTURE_PARITY_EN
        unsync_parity = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        check("rst_valid", 32'(sync_valid), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_bus", 32'(sync_bus), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        RST = 1'b0;

        // Async reset mid-cycle with two words stored.
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("midrst_valid", 32'(sync_valid), 32'd0);
        check("midrst_occ", 32'(occupancy), 32'd0);
        check("midrst_bus", 32'(sync_bus), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        q.delete();
        m_ovf = 1'b0;
        m_perr = 1'b0;
        @(negedge CLK);
        RST = 1'b0;

        // Single word held while not ready, then popped.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill, overflow drop, drain, clear.
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Push while full with a simultaneous pop.
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h44, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Clear racing a drop, then clear alone.
        cycle(1'b1, 8'h51, 1'b0, 1'b0);
        cycle(1'b1, 8'h52, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Push and pop with a single word stored: no bubble.
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        cycle(1'b1, 8'h88, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef DATA_SYNC_CAPTURE_PARITY_EN
        cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
`endif

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0));
        end
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
